sme_query_sequencer: RTL and testbench
======================================

// Module: sme_query_sequencer
// PURPOSE
//   Front-end controller for the SME string-match engine. Buffers one host frame, a string or a
//   pattern. Replays the frame to SME as one contiguous burst: one char per clk, isstring or
//   ispattern held high. SME has no stall, so bursts cannot be broken. For a pattern, waits for
//   SME valid and returns match/index as a tagged result over a ready/valid handshake.
// PARAMETERS
//   FRAME_MAX  32   max chars per frame (buffer depth)
//   TAG_W      4    width of pattern sequence tag
//   TIMEOUT    256  max cycles in WAIT before abort (used only with SME_TIMEOUT_EN)
// PORTS
//   clk             in   1      clock, all logic on rising edge
//   reset           in   1      synchronous, active-low: reset==0 at posedge resets block
//   in_valid        in   1      host char valid
//   in_ready        out  1      sequencer accepts char
//   in_char         in   8      char byte
//   in_type         in   1      0=string frame, 1=pattern frame (sampled on first beat)
//   in_last         in   1      last char of frame
//   sme_chardata    out  8      char to SME
//   sme_isstring    out  1      string burst active
//   sme_ispattern   out  1      pattern burst active
//   sme_valid       in   1      SME result valid
//   sme_match       in   1      SME match flag
//   sme_match_index in   5      SME match position
//   res_valid       out  1      result available
//   res_ready       in   1      host takes result
//   res_match       out  1      match flag
//   res_index       out  5      match position (0 when res_match=0)
//   res_tag         out  TAG_W  pattern sequence number
//   res_timeout     out  1      result is a timeout abort (tied 0 without SME_TIMEOUT_EN)
//   busy            out  1      state != IDLE
//   err_overflow    out  1      sticky: a frame exceeded FRAME_MAX
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, count 0, tag 0, have_string 0, err_overflow 0.
//     Reset mid-burst drops isstring/ispattern next edge; the partial burst is not resumed.
//   FSM: IDLE -> LOAD -> SEND -> (string) IDLE | (pattern) WAIT -> RESP -> IDLE.
//   IDLE/LOAD: in_ready=1. Each accepted beat writes buf[count], count++.
//     Beat with in_last -> SEND on next edge.
//   Overflow: beats past FRAME_MAX are accepted and discarded. err_overflow set.
//     Frame is truncated to FRAME_MAX chars.
//   SEND: in_ready=0. First char on sme_chardata the cycle after the in_last beat.
//     One char per cycle for exactly count cycles; isstring/ispattern high those cycles only.
//     Chardata holds last char when flags drop.
//   String frame: have_string<=1, tag<=0, back to IDLE after burst. No result generated.
//   Pattern frame with have_string=0: no burst. RESP directly with match=0, index=0.
//     Tag is consumed.
//   WAIT: sme_valid sampled only here (ignored in other states).
//     On sme_valid: capture match/index (index forced 0 if match=0), -> RESP.
//     res_valid rises the cycle after sme_valid.
//   RESP: res_* held stable while res_valid=1 && res_ready=0.
//     Transfer on res_valid&res_ready: tag++ (wraps mod 2^TAG_W), -> IDLE.
//     in_ready=0 until transfer.
//   Tag: value of pattern counter at frame start; first pattern after a string has tag 0.
// CONFIGURATION
//   SME_TIMEOUT_EN defined: 16-bit counter clears on entering WAIT.
//     If TIMEOUT cycles pass without sme_valid: -> RESP with match=0, index=0, res_timeout=1.
//     A late sme_valid is ignored outside WAIT.
//   SME_TIMEOUT_EN undefined: WAIT holds indefinitely; res_timeout tied 0; no counter logic.
// TESTING
//   String "abc" then pattern "b" (SME returns 1,1) -> isstring 3 cycles, ispattern 1 cycle;
//     result (1,1,tag0).
//   Two patterns after one string -> tags 0,1; new string frame -> next pattern tag 0.
//   Pattern before any string -> no ispattern pulse; result (0,0,tag0) within 3 cycles of in_last.
//   40-char string with FRAME_MAX=32 -> isstring high 32 cycles; err_overflow=1 until reset.
//   res_ready held 0 for 10 cycles -> res_* stable; in_ready=0; no new burst starts.
//   SME_TIMEOUT_EN, TIMEOUT=8, SME silent -> res_timeout=1 9 cycles after burst; reset mid-SEND -> flags 0.

Source files
------------

// File: rtl/sme_query_sequencer.sv
// sme_query_sequencer: buffers one host frame and replays it to the SME as one unbroken burst.
// Optional macro SME_TIMEOUT_EN adds an abort from WAIT after TIMEOUT silent cycles.
module sme_query_sequencer #(
    parameter int unsigned FRAME_MAX = 32,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic             in_type,
    input  logic             in_last,
    output logic [7:0]       sme_chardata,
    output logic             sme_isstring,
    output logic             sme_ispattern,
    input  logic             sme_valid,
    input  logic             sme_match,
    input  logic [4:0]       sme_match_index,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_match,
    output logic [4:0]       res_index,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_timeout,
    output logic             busy,
    output logic             err_overflow
);
    localparam int unsigned CW = $clog2(FRAME_MAX + 1);
    localparam int unsigned IW = $clog2(FRAME_MAX);
    localparam logic [CW-1:0] FMAX = CW'(FRAME_MAX);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, RESP} state_t;

    state_t            state;
    logic [7:0]        frame_buf [FRAME_MAX];
    logic [CW-1:0]     count;
    logic [CW-1:0]     send_idx;
    logic              is_pattern;
    logic              have_string;
    logic [TAG_W-1:0]  tag;
    logic              beat;
    logic              frame_pat;
    logic [7:0]        first_char;
    logic              timed_out;

    assign beat       = in_valid && in_ready;
    assign busy       = (state != IDLE);
    assign frame_pat  = (state == IDLE) ? in_type : is_pattern;
    // A one-char frame writes buf[0] on the same edge the burst starts, so bypass it.
    assign first_char = (count == '0) ? in_char : frame_buf[0];

`ifdef SME_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt;

    assign timed_out = (state == WAIT) && !sme_valid && (wait_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt    <= '0;
            res_timeout <= 1'b0;
        end else if (state == WAIT) begin
            if (sme_valid) begin
                res_timeout <= 1'b0;
            end else if (wait_cnt == TO_LAST) begin
                res_timeout <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end else begin
            wait_cnt <= '0;
            if (state != RESP) res_timeout <= 1'b0;
        end
    end
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
    assign timed_out      = 1'b0;
    assign res_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (beat && (count < FMAX)) frame_buf[count[IW-1:0]] <= in_char;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            sme_chardata  <= '0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            res_valid     <= 1'b0;
            res_match     <= 1'b0;
            res_index     <= '0;
            res_tag       <= '0;
            err_overflow  <= 1'b0;
            count         <= '0;
            send_idx      <= '0;
            is_pattern    <= 1'b0;
            have_string   <= 1'b0;
            tag           <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    in_ready <= 1'b1;
                    if (beat) begin
                        if (state == IDLE) is_pattern <= in_type;
                        if (count < FMAX) count <= count + 1'b1;
                        else              err_overflow <= 1'b1;
                        state <= LOAD;
                        if (in_last) begin
                            in_ready <= 1'b0;
                            if (frame_pat && !have_string) begin
                                state     <= RESP;
                                res_valid <= 1'b1;
                                res_match <= 1'b0;
                                res_index <= '0;
                                res_tag   <= tag;
                            end else begin
                                state         <= SEND;
                                sme_chardata  <= first_char;
                                sme_isstring  <= !frame_pat;
                                sme_ispattern <= frame_pat;
                                send_idx      <= CW'(1);
                            end
                        end
                    end
                end
                SEND: begin
                    if (send_idx < count) begin
                        sme_chardata <= frame_buf[send_idx[IW-1:0]];
                        send_idx     <= send_idx + 1'b1;
                    end else begin
                        sme_isstring  <= 1'b0;
                        sme_ispattern <= 1'b0;
                        count         <= '0;
                        if (is_pattern) begin
                            state <= WAIT;
                        end else begin
                            state       <= IDLE;
                            in_ready    <= 1'b1;
                            have_string <= 1'b1;
                            tag         <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (sme_valid) begin
                        state     <= RESP;
                        res_valid <= 1'b1;
                        res_match <= sme_match;
                        res_index <= sme_match ? sme_match_index : '0;
                        res_tag   <= tag;
                    end else if (timed_out) begin
                        state     <= RESP;
                        res_valid <= 1'b1;
                        res_match <= 1'b0;
                        res_index <= '0;
                        res_tag   <= tag;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        tag       <= tag + 1'b1;
                        count     <= '0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sme_query_sequencer.sv
// Self-checking bench for sme_query_sequencer: directed vector table, corner sequences, random frames.
module tb_sme_query_sequencer;
    localparam int unsigned FRAME_MAX  = 32;
    localparam int unsigned TAG_W      = 4;
    localparam int unsigned TB_TIMEOUT = 8;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic             ty;
        logic [63:0]      str;
        int               len;
        logic             sm;
        logic [4:0]       si;
        int               rdly;
        logic             burst;
        logic             exp_m;
        logic [4:0]       exp_i;
        logic [TAG_W-1:0] exp_tag;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready, in_type, in_last;
    logic [7:0]       in_char, sme_chardata;
    logic             sme_isstring, sme_ispattern, sme_valid, sme_match;
    logic [4:0]       sme_match_index, res_index;
    logic             res_valid, res_ready, res_match, res_timeout, busy, err_overflow;
    logic [TAG_W-1:0] res_tag;

    int   checks   = 0;
    int   failures = 0;
    logic exp_ovf  = 1'b0;

    // Reference model state for the random phase
    logic             m_have;
    logic [TAG_W-1:0] m_tag;

    sme_query_sequencer #(.FRAME_MAX(FRAME_MAX), .TAG_W(TAG_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .in_type(in_type), .in_last(in_last), .sme_chardata(sme_chardata),
        .sme_isstring(sme_isstring), .sme_ispattern(sme_ispattern), .sme_valid(sme_valid),
        .sme_match(sme_match), .sme_match_index(sme_match_index), .res_valid(res_valid),
        .res_ready(res_ready), .res_match(res_match), .res_index(res_index), .res_tag(res_tag),
        .res_timeout(res_timeout), .busy(busy), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic byte_q_t to_q(input logic [63:0] s, input int len);
        byte_q_t q;
        for (int k = 0; k < len; k++) q.push_back(s[8*(len-1-k) +: 8]);
        return q;
    endfunction

    function automatic vec_t mk(input logic ty, input logic [63:0] s, input int len, input logic sm,
                                input logic [4:0] si, input int rdly, input logic burst,
                                input logic em, input logic [4:0] ei, input logic [TAG_W-1:0] et);
        vec_t v;
        v.ty = ty; v.str = s; v.len = len; v.sm = sm; v.si = si; v.rdly = rdly;
        v.burst = burst; v.exp_m = em; v.exp_i = ei; v.exp_tag = et;
        return v;
    endfunction

    task automatic drive_frame(input logic ty, input byte_q_t chars);
        logic acc;
        int   budget;
        for (int i = 0; i < chars.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_char  = chars[i];
            in_last  = (i == chars.size() - 1);
            in_type  = (i == 0) ? ty : 1'($urandom_range(0, 1));
            budget   = 0;
            do begin
                acc = in_ready;
                step();
                budget++;
            end while (!acc && budget < 20);
            chk("beat_accept", acc, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_burst(input logic ty, input byte_q_t chars, input int n);
        for (int k = 0; k < n; k++) begin
            chk("burst_flag", ty ? sme_ispattern : sme_isstring, 1);
            chk("burst_other_flag", ty ? sme_isstring : sme_ispattern, 0);
            chk("burst_char", sme_chardata, chars[k]);
            sme_valid = ($urandom_range(0, 3) == 0);
            sme_match = 1'($urandom);
            step();
        end
        sme_valid = 1'b0;
        chk("burst_end_flags", {sme_isstring, sme_ispattern}, 0);
        chk("burst_end_hold_char", sme_chardata, chars[n-1]);
    endtask

    task automatic run_frame(input logic ty, input byte_q_t chars, input logic sm, input logic [4:0] si,
                             input int wdly, input int rdly, input logic burst, input logic exp_m,
                             input logic [4:0] exp_i, input logic [TAG_W-1:0] exp_tag, input logic exp_to);
        int          n;
        int          cnt;
        logic [10:0] held;
        n = (chars.size() > FRAME_MAX) ? FRAME_MAX : chars.size();
        drive_frame(ty, chars);
        if (burst) begin
            check_burst(ty, chars, n);
        end else begin
            cnt = 0;
            while (!res_valid && cnt < 3) begin
                chk("nostring_no_burst", {sme_isstring, sme_ispattern}, 0);
                step();
                cnt++;
            end
            chk("nostring_no_burst", {sme_isstring, sme_ispattern}, 0);
        end
        if (!ty) begin
            chk("string_idle_busy", busy, 0);
            chk("string_idle_ready", in_ready, 1);
            chk("string_no_result", res_valid, 0);
        end else begin
            if (burst && !exp_to) begin
                for (int k = 0; k < wdly; k++) begin
                    chk("wait_no_result", res_valid, 0);
                    chk("wait_busy", busy, 1);
                    sme_match = 1'($urandom);
                    step();
                end
                sme_valid       = 1'b1;
                sme_match       = sm;
                sme_match_index = si;
                step();
                sme_valid       = 1'b0;
                sme_match       = 1'($urandom);
                sme_match_index = 5'($urandom);
            end else if (exp_to) begin
                cnt = 0;
                while (!res_valid && cnt < 4 * TB_TIMEOUT) begin
                    step();
                    cnt++;
                end
                chk("timeout_latency", cnt, TB_TIMEOUT);
            end
            chk("res_valid", res_valid, 1);
            chk("res_match", res_match, exp_m);
            chk("res_index", res_index, exp_i);
            chk("res_tag", res_tag, exp_tag);
            chk("res_timeout", res_timeout, exp_to);
            held = {res_valid, res_match, res_index, res_tag};
            for (int k = 0; k < rdly; k++) begin
                in_valid  = 1'b1;
                in_char   = 8'($urandom);
                sme_valid = 1'($urandom);
                step();
                chk("stall_hold", {res_valid, res_match, res_index, res_tag}, held);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_no_burst", {sme_isstring, sme_ispattern}, 0);
            end
            in_valid  = 1'b0;
            sme_valid = 1'b0;
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            chk("xfer_res_valid", res_valid, 0);
            chk("xfer_in_ready", in_ready, 1);
            chk("xfer_busy", busy, 0);
        end
        chk("err_overflow", err_overflow, exp_ovf);
    endtask

    vec_t    vecs [8];
    byte_q_t q;

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_char = '0; in_type = 1'b0; in_last = 1'b0;
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0; res_ready = 1'b0;
        step();
        step();
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_flags", {sme_isstring, sme_ispattern}, 0);
        chk("reset_chardata", sme_chardata, 0);
        chk("reset_res", {res_valid, res_match, res_index, res_tag, res_timeout}, 0);
        chk("reset_err", err_overflow, 0);
        reset = 1'b1;

        vecs[0] = mk(1'b1, "q",     1, 1'b1, 5'd3,  0,  1'b0, 1'b0, 5'd0,  4'd0);
        vecs[1] = mk(1'b0, "abc",   3, 1'b0, 5'd0,  0,  1'b1, 1'b0, 5'd0,  4'd0);
        vecs[2] = mk(1'b1, "b",     1, 1'b1, 5'd1,  1,  1'b1, 1'b1, 5'd1,  4'd0);
        vecs[3] = mk(1'b1, "xy",    2, 1'b0, 5'd7,  10, 1'b1, 1'b0, 5'd0,  4'd1);
        vecs[4] = mk(1'b1, "c",     1, 1'b1, 5'd2,  2,  1'b1, 1'b1, 5'd2,  4'd2);
        vecs[5] = mk(1'b0, "hello", 5, 1'b1, 5'd9,  0,  1'b1, 1'b0, 5'd0,  4'd0);
        vecs[6] = mk(1'b1, "lo",    2, 1'b1, 5'd3,  0,  1'b1, 1'b1, 5'd3,  4'd0);
        vecs[7] = mk(1'b1, "z",     1, 1'b1, 5'd31, 3,  1'b1, 1'b1, 5'd31, 4'd1);
        for (int v = 0; v < 8; v++) begin
            q = to_q(vecs[v].str, vecs[v].len);
            run_frame(vecs[v].ty, q, vecs[v].sm, vecs[v].si, 2, vecs[v].rdly, vecs[v].burst,
                      vecs[v].exp_m, vecs[v].exp_i, vecs[v].exp_tag, 1'b0);
        end

        // 40-char string truncates to 32 and leaves err_overflow set
        q = {};
        for (int k = 0; k < 40; k++) q.push_back(8'($urandom));
        exp_ovf = 1'b1;
        run_frame(1'b0, q, 1'b0, 5'd0, 0, 0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        q = to_q("ab", 2);
        run_frame(1'b1, q, 1'b1, 5'd5, 1, 0, 1'b1, 1'b1, 5'd5, 4'd0, 1'b0);

        // Reset in the middle of a burst
        q = {};
        for (int k = 0; k < 10; k++) q.push_back(8'($urandom));
        drive_frame(1'b0, q);
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("midreset_flags", {sme_isstring, sme_ispattern}, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_err", err_overflow, 0);
        chk("midreset_in_ready", in_ready, 0);
        reset   = 1'b1;
        exp_ovf = 1'b0;
        q = to_q("q", 1);
        run_frame(1'b1, q, 1'b1, 5'd4, 0, 0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);

`ifdef SME_TIMEOUT_EN
        q = to_q("ab", 2);
        run_frame(1'b0, q, 1'b0, 5'd0, 0, 0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        q = to_q("a", 1);
        run_frame(1'b1, q, 1'b0, 5'd0, 0, 1, 1'b1, 1'b0, 5'd0, 4'd0, 1'b1);
`endif

        reset = 1'b0;
        step();
        reset   = 1'b1;
        m_have  = 1'b0;
        m_tag   = '0;
        exp_ovf = 1'b0;
        for (int f = 0; f < 40; f++) begin
            logic       ty, sm, bst, em;
            logic [4:0] si, ei;
            int         len;
            ty  = ($urandom_range(0, 2) != 0);
            len = ($urandom_range(0, 7) == 0) ? 33 + $urandom_range(0, 5) : 1 + $urandom_range(0, 31);
            sm  = 1'($urandom);
            si  = 5'($urandom);
            q = {};
            for (int k = 0; k < len; k++) q.push_back(8'($urandom));
            bst = !ty || m_have;
            em  = bst && sm;
            ei  = em ? si : 5'd0;
            if (len > FRAME_MAX) exp_ovf = 1'b1;
            run_frame(ty, q, sm, si, $urandom_range(0, 5), $urandom_range(0, 4), bst, em, ei, m_tag, 1'b0);
            if (!ty) begin
                m_have = 1'b1;
                m_tag  = '0;
            end else begin
                m_tag = m_tag + 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
